dataflow_out_buffer: RTL and testbench

Elastic output buffer sitting directly downstream of the basic dataflow stage. Captures its 8-bit result stream, which has no backpressure, into a small FIFO and re-presents it on a valid/ready interface to the consumer. Samples arriving while full are dropped and counted. An almost-full flag is provided for flow monitoring.

---
 rtl/dataflow_pkg.sv | 6 +
 rtl/dataflow_fifo_mem.sv | 23 ++
 rtl/dataflow_out_buffer.sv | 89 ++++++++
 tb/tb_dataflow_out_buffer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dataflow_pkg.sv
// Shared types and constants for the dataflow stage and its output buffer.
package dataflow_pkg;
    localparam int DATA_W = 8;
    typedef logic [DATA_W-1:0] data_t;
    localparam data_t DROP_CNT_MAX = 8'hFF;
endpackage

// File: rtl/dataflow_fifo_mem.sv
// DEPTH x data_t storage: one synchronous write port, one asynchronous read port, no reset.
module dataflow_fifo_mem
    import dataflow_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  data_t                    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output data_t                    rdata
);
    data_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/dataflow_out_buffer.sv
// Elastic FIFO buffer re-presenting the dataflow result stream on valid/ready; overflow drops are counted.
// Optional popped-byte checksum is enabled by DATAFLOW_OUT_BUFFER_CSUM_EN.
module dataflow_out_buffer
    import dataflow_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  data_t                      in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output data_t                      out_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       almost_full,
    output data_t                      drop_cnt
`ifdef DATAFLOW_OUT_BUFFER_CSUM_EN
    ,
    input  logic                       csum_clr,
    output data_t                      csum
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          drop;
    data_t         rd_data;

    assign out_valid   = (level != '0);
    assign pop         = out_valid & out_ready;
    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    assign push        = in_valid & ((level < LW'(DEPTH)) | pop);
    assign drop        = in_valid & ~push;
    assign almost_full = (level >= LW'(AF_THRESH));
    assign out_data    = out_valid ? rd_data : '0;

    dataflow_fifo_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (drop && (drop_cnt != DROP_CNT_MAX)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

`ifdef DATAFLOW_OUT_BUFFER_CSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= '0;
        end else if (csum_clr) begin
            csum <= pop ? out_data : '0;
        end else if (pop) begin
            csum <= csum + out_data;
        end
    end
`endif
endmodule

// File: tb/tb_dataflow_out_buffer.sv
// Scoreboard bench for dataflow_out_buffer: a reference model predicts occupancy, drops and popped data.
module tb_dataflow_out_buffer;
    import dataflow_pkg::*;

    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        in_valid  = 1'b0;
    data_t       in_data   = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    data_t       out_data;
    logic [2:0]  level;
    logic        almost_full;
    data_t       drop_cnt;
`ifdef DATAFLOW_OUT_BUFFER_CSUM_EN
    logic        csum_clr = 1'b0;
    data_t       csum;
    data_t       mcsum = '0;
`endif

    int    checks = 0;
    int    errors = 0;
    data_t sb[$];
    int    mlevel = 0;
    int    mdrop  = 0;

    always #5 clk = ~clk;

    dataflow_out_buffer #(
        .DEPTH     (DEPTH),
        .AF_THRESH (AF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
        .almost_full (almost_full),
        .drop_cnt    (drop_cnt)
`ifdef DATAFLOW_OUT_BUFFER_CSUM_EN
        ,
        .csum_clr    (csum_clr),
        .csum        (csum)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        mlevel = 0;
        mdrop  = 0;
`ifdef DATAFLOW_OUT_BUFFER_CSUM_EN
        mcsum  = '0;
`endif
    endtask

    // Called just after a rising edge; checks at the falling edge, then advances the model.
    task automatic cycle(input logic v, input data_t d, input logic r);
        logic  pop;
        logic  push;
        data_t head;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(negedge clk);
        check_val("out_valid", 32'(out_valid), 32'(mlevel != 0));
        check_val("level", 32'(level), 32'(mlevel));
        check_val("almost_full", 32'(almost_full), 32'(mlevel >= AF));
        check_val("drop_cnt", 32'(drop_cnt), 32'(mdrop));
        if (mlevel != 0) check_val("out_data", 32'(out_data), 32'(sb[0]));
        else             check_val("out_data_empty", 32'(out_data), 32'h0);
`ifdef DATAFLOW_OUT_BUFFER_CSUM_EN
        check_val("csum", 32'(csum), 32'(mcsum));
`endif
        pop  = (mlevel != 0) && r;
        push = v && ((mlevel < DEPTH) || pop);
        head = (mlevel != 0) ? sb[0] : '0;
        if (pop)  void'(sb.pop_front());
        if (push) sb.push_back(d);
        mlevel = mlevel + int'(push) - int'(pop);
        if (v && !push && mdrop < 255) mdrop++;
`ifdef DATAFLOW_OUT_BUFFER_CSUM_EN
        if (csum_clr)  mcsum = pop ? head : '0;
        else if (pop)  mcsum = mcsum + head;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'h0);
        check_val("rst_level", 32'(level), 32'h0);
        check_val("rst_almost_full", 32'(almost_full), 32'h0);
        check_val("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        check_val("rst_out_data", 32'(out_data), 32'h0);
        rst = 1'b0;
        model_reset();
        repeat (3) cycle(1'b0, 8'h00, 1'b0);

        // Asynchronous reset mid-stream with three entries held
        for (int i = 0; i < 3; i++) cycle(1'b1, data_t'(8'h10 + i), 1'b0);
        in_valid = 1'b0;
        check_val("pre_rst_level", 32'(level), 32'h3);
        rst = 1'b1;
        #1;
        check_val("async_rst_level", 32'(level), 32'h0);
        check_val("async_rst_out_valid", 32'(out_valid), 32'h0);
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        cycle(1'b0, 8'h00, 1'b0);

        // Single push held for several cycles
        cycle(1'b1, 8'h22, 1'b0);
        repeat (4) cycle(1'b0, 8'h00, 1'b0);
        check_val("hold_out_data", 32'(out_data), 32'h22);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Overfill, then full with simultaneous push and pop
        for (int i = 1; i <= 6; i++) cycle(1'b1, data_t'(i), 1'b0);
        check_val("overfill_drops", 32'(drop_cnt), 32'h2);
        check_val("overfill_level", 32'(level), 32'h4);
        cycle(1'b1, 8'hAA, 1'b1);
        check_val("full_pushpop_level", 32'(level), 32'h4);
        check_val("full_pushpop_drops", 32'(drop_cnt), 32'h2);
        repeat (6) cycle(1'b0, 8'h00, 1'b1);

        // Streaming at full rate across pointer wrap
`ifdef DATAFLOW_OUT_BUFFER_CSUM_EN
        csum_clr = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        csum_clr = 1'b0;
`endif
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, data_t'(i[7:0]), 1'b1);
`ifdef DATAFLOW_OUT_BUFFER_CSUM_EN
            if (i == 256) check_val("csum_256", 32'(csum), 32'h80);
`endif
        end
        repeat (2) cycle(1'b0, 8'h00, 1'b1);
`ifdef DATAFLOW_OUT_BUFFER_CSUM_EN
        csum_clr = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        csum_clr = 1'b0;
        check_val("csum_clr", 32'(csum), 32'h0);
`endif
        check_val("stream_drops", 32'(drop_cnt), 32'h2);

        // Drop counter saturation
        for (int i = 0; i < 310; i++) cycle(1'b1, 8'h55, 1'b0);
        check_val("drop_sat", 32'(drop_cnt), 32'hFF);
        repeat (6) cycle(1'b0, 8'h00, 1'b1);
        check_val("drop_hold", 32'(drop_cnt), 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
